nn_sequencer: RTL and testbench



---
 rtl/nn_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_nn_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sequencer.sv
// nn_sequencer: job-level control unit for the neural-network datapath.
// Accepts inference/training jobs over valid/ready, runs forward propagation
// layer by layer, then either back propagation (training) or display
// (inference). Every batch_size training samples it requests a weight update.
// Optional build macro NN_SEQ_TIMEOUT_EN adds a watchdog that forces IDLE
// after TIMEOUT_CYC cycles in one busy state and pulses timeout_err.
module nn_sequencer #(
  parameter int unsigned IMG_SZ      = 6272,
  parameter int unsigned LABEL_W     = 8,
  parameter int unsigned NUM_LAYERS  = 3,
  parameter int unsigned BATCH_MAX   = 64,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  localparam int unsigned CNT_W      = $clog2(BATCH_MAX + 1),
  localparam int unsigned IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_train,
  input  logic [LABEL_W-1:0] req_label,
  input  logic [IMG_SZ-1:0]  req_image,
  input  logic [CNT_W-1:0]   batch_size,
  input  logic               abort,
  output logic               layer_start,
  output logic [IDX_W-1:0]   layer_idx,
  output logic               fwd,
  input  logic               layer_done,
  output logic               upd_start,
  input  logic               upd_done,
  output logic               draw,
  input  logic               drawn,
  output logic               ack,
  output logic               ack_train,
  output logic [LABEL_W-1:0] label_out,
  output logic [IMG_SZ-1:0]  image_out,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {StIdle, StFp, StBp, StUpd, StDisp} state_e;

  state_e r_state;
  state_e w_state_d;

  // Registered outputs and their next-state values
  logic               r_layer_start, w_layer_start_d;
  logic [IDX_W-1:0]   r_layer_idx,   w_layer_idx_d;
  logic               r_fwd,         w_fwd_d;
  logic               r_upd_start,   w_upd_start_d;
  logic               r_draw,        w_draw_d;
  logic               r_ack,         w_ack_d;
  logic               r_ack_train,   w_ack_train_d;
  logic [CNT_W-1:0]   r_sample_cnt,  w_sample_cnt_d;
  logic [LABEL_W-1:0] r_label;
  logic [IMG_SZ-1:0]  r_image;
  logic               r_train;

  logic               w_accept;
  logic               w_ld_ok;
  logic               w_last_fwd;
  logic               w_first_layer;
  logic [CNT_W-1:0]   w_bs_eff;
  logic [CNT_W:0]     w_cnt_inc;
  logic               w_bs_hit;
  logic               w_timeout;
  logic               w_kill;

  assign w_accept      = (r_state == StIdle) && req_valid;
  // The engine needs at least one cycle, so a done coinciding with start is stale.
  assign w_ld_ok       = layer_done && !r_layer_start;
  assign w_last_fwd    = (r_layer_idx == IDX_W'(NUM_LAYERS - 1));
  assign w_first_layer = (r_layer_idx == '0);
  assign w_bs_eff      = (batch_size == '0) ? CNT_W'(1) : batch_size;
  // One extra bit so sample_cnt+1 cannot wrap before the compare.
  assign w_cnt_inc     = {1'b0, r_sample_cnt} + (CNT_W + 1)'(1);
  assign w_bs_hit      = (w_cnt_inc >= {1'b0, w_bs_eff});
  assign w_kill        = (r_state != StIdle) && (abort || w_timeout);

`ifdef NN_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  assign w_timeout = (r_state != StIdle) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog: restart on every state change, count while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_state_d != r_state) begin
      r_to_cnt <= '0;
    end else if (r_state != StIdle) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // One-cycle error pulse coincides with the forced return to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign timeout_err      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode; abort/timeout override any done input
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (req_valid) w_state_d = StFp;
      end
      StFp: begin
        if (w_ld_ok && w_last_fwd) w_state_d = r_train ? StBp : StDisp;
      end
      StBp: begin
        if (w_ld_ok && w_first_layer) w_state_d = w_bs_hit ? StUpd : StIdle;
      end
      StUpd: begin
        if (upd_done) w_state_d = StIdle;
      end
      StDisp: begin
        if (drawn) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (w_kill) w_state_d = StIdle;
  end

  // Next values of the registered outputs
  always_comb begin
    w_layer_start_d = 1'b0;
    w_upd_start_d   = 1'b0;
    w_ack_d         = 1'b0;
    w_ack_train_d   = r_ack_train;
    w_layer_idx_d   = r_layer_idx;
    w_fwd_d         = r_fwd;
    w_draw_d        = r_draw;
    w_sample_cnt_d  = r_sample_cnt;
    case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_layer_start_d = 1'b1;
          w_layer_idx_d   = '0;
          w_fwd_d         = 1'b1;
        end
      end
      StFp: begin
        if (w_ld_ok) begin
          if (!w_last_fwd) begin
            w_layer_idx_d   = r_layer_idx + IDX_W'(1);
            w_layer_start_d = 1'b1;
          end else if (r_train) begin
            // Back propagation starts from the layer just finished
            w_layer_idx_d   = IDX_W'(NUM_LAYERS - 1);
            w_fwd_d         = 1'b0;
            w_layer_start_d = 1'b1;
          end else begin
            w_draw_d = 1'b1;
          end
        end
      end
      StBp: begin
        if (w_ld_ok) begin
          if (!w_first_layer) begin
            w_layer_idx_d   = r_layer_idx - IDX_W'(1);
            w_layer_start_d = 1'b1;
          end else if (w_bs_hit) begin
            w_upd_start_d = 1'b1;
          end else begin
            w_sample_cnt_d = r_sample_cnt + CNT_W'(1);
            w_ack_d        = 1'b1;
            w_ack_train_d  = 1'b1;
          end
        end
      end
      StUpd: begin
        if (upd_done) begin
          w_sample_cnt_d = '0;
          w_ack_d        = 1'b1;
          w_ack_train_d  = 1'b1;
        end
      end
      StDisp: begin
        if (drawn) begin
          w_draw_d      = 1'b0;
          w_ack_d       = 1'b1;
          w_ack_train_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Abort drops pending pulses and the display request, keeps the batch count
    if (w_kill) begin
      w_layer_start_d = 1'b0;
      w_upd_start_d   = 1'b0;
      w_ack_d         = 1'b0;
      w_ack_train_d   = r_ack_train;
      w_layer_idx_d   = r_layer_idx;
      w_fwd_d         = r_fwd;
      w_draw_d        = 1'b0;
      w_sample_cnt_d  = r_sample_cnt;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_layer_start <= 1'b0;
      r_layer_idx   <= '0;
      r_fwd         <= 1'b1;
      r_upd_start   <= 1'b0;
      r_draw        <= 1'b0;
      r_ack         <= 1'b0;
      r_ack_train   <= 1'b0;
      r_sample_cnt  <= '0;
    end else begin
      r_layer_start <= w_layer_start_d;
      r_layer_idx   <= w_layer_idx_d;
      r_fwd         <= w_fwd_d;
      r_upd_start   <= w_upd_start_d;
      r_draw        <= w_draw_d;
      r_ack         <= w_ack_d;
      r_ack_train   <= w_ack_train_d;
      r_sample_cnt  <= w_sample_cnt_d;
    end
  end

  // Job capture on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_train <= 1'b0;
      r_label <= '0;
      r_image <= '0;
    end else if (w_accept) begin
      r_train <= req_train;
      r_label <= req_label;
      r_image <= req_image;
    end
  end

  assign req_ready   = (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign layer_start = r_layer_start;
  assign layer_idx   = r_layer_idx;
  assign fwd         = r_fwd;
  assign upd_start   = r_upd_start;
  assign draw        = r_draw;
  assign ack         = r_ack;
  assign ack_train   = r_ack_train;
  assign sample_cnt  = r_sample_cnt;
  assign label_out   = r_label;
  assign image_out   = r_image;

endmodule

// File: tb/tb_nn_sequencer.sv
// Self-checking bench for nn_sequencer: directed job scenarios with literal
// expectations, then randomized inputs checked every cycle against a
// job-level behavioural model.
module tb_nn_sequencer;
  localparam int unsigned IMG_SZ      = 6272;
  localparam int unsigned LABEL_W     = 8;
  localparam int unsigned NUM_LAYERS  = 3;
  localparam int unsigned BATCH_MAX   = 64;
  localparam int unsigned TIMEOUT_CYC = 1000000;
  localparam int unsigned CNT_W       = $clog2(BATCH_MAX + 1);
  localparam int unsigned IDX_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic               req_train;
  logic [LABEL_W-1:0] req_label;
  logic [IMG_SZ-1:0]  req_image;
  logic [CNT_W-1:0]   batch_size;
  logic               abort;
  logic               layer_start;
  logic [IDX_W-1:0]   layer_idx;
  logic               fwd;
  logic               layer_done = 1'b0;
  logic               upd_start;
  logic               upd_done = 1'b0;
  logic               draw;
  logic               drawn = 1'b0;
  logic               ack;
  logic               ack_train;
  logic [LABEL_W-1:0] label_out;
  logic [IMG_SZ-1:0]  image_out;
  logic [CNT_W-1:0]   sample_cnt;
  logic               busy;
  logic               timeout_err;

  nn_sequencer #(
    .IMG_SZ     (IMG_SZ),
    .LABEL_W    (LABEL_W),
    .NUM_LAYERS (NUM_LAYERS),
    .BATCH_MAX  (BATCH_MAX),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_train  (req_train),
    .req_label  (req_label),
    .req_image  (req_image),
    .batch_size (batch_size),
    .abort      (abort),
    .layer_start(layer_start),
    .layer_idx  (layer_idx),
    .fwd        (fwd),
    .layer_done (layer_done),
    .upd_start  (upd_start),
    .upd_done   (upd_done),
    .draw       (draw),
    .drawn      (drawn),
    .ack        (ack),
    .ack_train  (ack_train),
    .label_out  (label_out),
    .image_out  (image_out),
    .sample_cnt (sample_cnt),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_img(input string name, input logic [IMG_SZ-1:0] exp);
    n_tests++;
    if (image_out !== exp) begin
      n_fail++;
      $display("FAIL %s: got low64 %h expected low64 %h (t=%0t)", name, image_out[63:0],
               exp[63:0], $time);
    end
  endtask

  task automatic rand_img(output logic [IMG_SZ-1:0] v);
    v = '0;
    for (int i = 0; i < IMG_SZ / 32; i++) v[i*32 +: 32] = $urandom;
  endtask

  // ---------------- behavioural model ----------------
  // A job walks a flat step counter over 2*NUM_LAYERS layer executions:
  // steps 0..N-1 are forward layers 0..N-1, steps N..2N-1 are backward N-1..0.
  // Phases: 0 idle, 1 running layers, 2 waiting for update, 3 displaying.
  bit                 model_en = 1'b0;
  int                 m_phase  = 0;
  int                 m_step   = 0;
  int                 m_cnt    = 0;
  bit                 m_train  = 1'b0;
  bit                 m_ls     = 1'b0;
  bit                 m_upd    = 1'b0;
  bit                 m_ack    = 1'b0;
  bit                 m_ackt   = 1'b0;
  logic [LABEL_W-1:0] m_label  = '0;
  logic [IMG_SZ-1:0]  m_img    = '0;

  function automatic int exp_idx(input int s);
    return (s < NUM_LAYERS) ? s : 2 * NUM_LAYERS - 1 - s;
  endfunction

  // Observation logs for the directed scenarios
  int ls_log[$];
  int upd_seen  = 0;

  always @(posedge clk) begin
    bit nls, nupd, nack;
    int bs;
    if (model_en) begin
      nls  = 1'b0;
      nupd = 1'b0;
      nack = 1'b0;
      if (m_phase == 0) begin
        if (req_valid) begin
          m_phase = 1;
          m_step  = 0;
          m_train = req_train;
          m_img   = req_image;
          m_label = req_label;
          nls     = 1'b1;
        end
      end else if (abort) begin
        m_phase = 0;
      end else begin
        case (m_phase)
          1: begin
            if (layer_done && !m_ls) begin
              if (m_step == NUM_LAYERS - 1 && !m_train) begin
                m_phase = 3;
              end else if (m_step == 2 * NUM_LAYERS - 1) begin
                bs = (int'(batch_size) == 0) ? 1 : int'(batch_size);
                if (m_cnt + 1 >= bs) begin
                  m_phase = 2;
                  nupd    = 1'b1;
                end else begin
                  m_cnt++;
                  m_phase = 0;
                  nack    = 1'b1;
                  m_ackt  = 1'b1;
                end
              end else begin
                m_step++;
                nls = 1'b1;
              end
            end
          end
          2: begin
            if (upd_done) begin
              m_cnt   = 0;
              m_phase = 0;
              nack    = 1'b1;
              m_ackt  = 1'b1;
            end
          end
          3: begin
            if (drawn) begin
              m_phase = 0;
              nack    = 1'b1;
              m_ackt  = 1'b0;
            end
          end
          default: ;
        endcase
      end
      m_ls  = nls;
      m_upd = nupd;
      m_ack = nack;
      #1;
      check("req_ready", req_ready, m_phase == 0);
      check("busy", busy, m_phase != 0);
      check("layer_start", layer_start, m_ls);
      check("upd_start", upd_start, m_upd);
      check("ack", ack, m_ack);
      if (m_ack) check("ack_train", ack_train, m_ackt);
      check("draw", draw, m_phase == 3);
      check("layer_idx", layer_idx, exp_idx(m_step));
      check("fwd", fwd, m_step < NUM_LAYERS);
      check("sample_cnt", sample_cnt, m_cnt);
      check("label_out", label_out, m_label);
      check_img("image_out", m_img);
      check("timeout_err", timeout_err, 1'b0);
      if (layer_start) ls_log.push_back(int'(layer_idx));
      if (upd_start) upd_seen++;
      if (n_fail >= 50) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  // ---------------- engine responders ----------------
  bit rnd_mode = 1'b0;
  int ld_cnt = 0;
  int ud_cnt = 0;
  int dr_cnt = 0;
  bit draw_prev = 1'b0;

  // Directed: layer_done 4 cycles after layer_start, upd_done 3, drawn 4
  always @(negedge clk) begin
    if (rnd_mode) begin
      layer_done = ($urandom_range(99) < 35);
      upd_done   = ($urandom_range(99) < 35);
      drawn      = ($urandom_range(99) < 35);
    end else begin
      layer_done = 1'b0;
      upd_done   = 1'b0;
      drawn      = 1'b0;
      if (!busy) begin
        ld_cnt = 0;
        ud_cnt = 0;
        dr_cnt = 0;
      end else begin
        if (ld_cnt != 0) begin
          ld_cnt--;
          if (ld_cnt == 0) layer_done = 1'b1;
        end
        if (layer_start) ld_cnt = 3;
        if (ud_cnt != 0) begin
          ud_cnt--;
          if (ud_cnt == 0) upd_done = 1'b1;
        end
        if (upd_start) ud_cnt = 2;
        if (dr_cnt != 0) begin
          dr_cnt--;
          if (dr_cnt == 0) drawn = 1'b1;
        end
        if (draw && !draw_prev) dr_cnt = 3;
      end
    end
    draw_prev = draw;
  end

  // ---------------- directed helpers ----------------
  task automatic start_job(input bit train, input logic [LABEL_W-1:0] lab);
    logic [IMG_SZ-1:0] img;
    @(negedge clk);
    rand_img(img);
    req_image = img;
    req_label = lab;
    req_train = train;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Returns positioned 2 time units after the edge that raised ack
  task automatic wait_ack(input string name, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk);
      #2;
      if (ack) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: got no ack expected ack within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    bit ok;
    ok = (ls_log.size() == exp.size());
    for (int i = 0; i < exp.size() && ok; i++) if (ls_log[i] != exp[i]) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %p expected %p", name, ls_log, exp);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [IMG_SZ-1:0] img_b;
    bit found;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_train  = 1'b0;
    req_label  = '0;
    req_image  = '0;
    batch_size = '0;
    abort      = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fwd", fwd, 1'b1);
    check("rst_layer_start", layer_start, 1'b0);
    check("rst_layer_idx", layer_idx, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    check("rst_draw", draw, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_label", label_out, 0);
    check_img("rst_image", '0);
    @(negedge clk);
    rst      = 1'b0;
    model_en = 1'b1;

    // Inference job
    batch_size = CNT_W'(2);
    ls_log.delete();
    start_job(1'b0, 8'h5A);
    wait_ack("inf_ack", 200);
    check_seq("inf_layers", '{0, 1, 2});
    check("inf_ack_train", ack_train, 1'b0);
    check("inf_req_ready", req_ready, 1'b1);
    check("inf_label", label_out, 8'h5A);

    // Two training jobs, batch of 2
    ls_log.delete();
    upd_seen = 0;
    start_job(1'b1, 8'h11);
    wait_ack("tr1_ack", 300);
    check_seq("tr1_layers", '{0, 1, 2, 2, 1, 0});
    check("tr1_sample_cnt", sample_cnt, 1);
    check("tr1_ack_train", ack_train, 1'b1);
    check("tr1_no_upd", upd_seen, 0);
    start_job(1'b1, 8'h22);
    wait_ack("tr2_ack", 300);
    check("tr2_upd", upd_seen, 1);
    check("tr2_sample_cnt", sample_cnt, 0);

    // batch_size 0 behaves as 1
    batch_size = '0;
    upd_seen   = 0;
    start_job(1'b1, 8'h33);
    wait_ack("bs0_ack", 300);
    check("bs0_upd", upd_seen, 1);
    check("bs0_sample_cnt", sample_cnt, 0);

    // Abort during backward layer 1
    batch_size = CNT_W'(4);
    start_job(1'b1, 8'h44);
    wait_ack("pre_abort_ack", 300);
    check("pre_abort_cnt", sample_cnt, 1);
    start_job(1'b1, 8'h55);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #2;
      if (layer_start && !fwd && layer_idx == IDX_W'(1)) found = 1'b1;
    end
    check("abort_reach_bp1", found, 1'b1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #2;
    check("abort_busy", busy, 1'b0);
    check("abort_ack", ack, 1'b0);
    check("abort_cnt", sample_cnt, 1);
    @(negedge clk);
    abort = 1'b0;
    ls_log.delete();
    start_job(1'b0, 8'h66);
    wait_ack("post_abort_ack", 200);
    check_seq("post_abort_layers", '{0, 1, 2});

    // Back-to-back: valid held through ack
    @(negedge clk);
    rand_img(img_b);
    req_image = img_b;
    req_label = 8'h77;
    req_train = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    rand_img(img_b);
    req_image = img_b;
    req_label = 8'h88;
    wait_ack("b2b_first_ack", 200);
    check("b2b_ack_ready", req_ready, 1'b1);
    check("b2b_first_label", label_out, 8'h77);
    @(posedge clk);
    #2;
    check("b2b_layer_start", layer_start, 1'b1);
    check("b2b_layer_idx", layer_idx, 0);
    check_img("b2b_image", img_b);
    check("b2b_label", label_out, 8'h88);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ack("b2b_second_ack", 200);

    // Randomized traffic
    rnd_mode = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      req_valid  = ($urandom_range(99) < 50);
      req_train  = $urandom_range(1);
      req_label  = LABEL_W'($urandom);
      batch_size = CNT_W'($urandom_range(4));
      abort      = ($urandom_range(99) < 3);
      rand_img(img_b);
      req_image = img_b;
    end
    @(negedge clk);
    req_valid = 1'b0;
    abort     = 1'b0;
    rnd_mode  = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
